adder_pipe_carry: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor with carry-in, carry-out and signed overflow.
- Successor to the combinational N-bit carry adder. Splits the carry chain into STAGES equal chunks, one chunk resolved per pipeline stage, so wide adds meet timing.
- Uses a valid/ready handshake on both sides with full backpressure. Sits between operand-fetch logic and result-writeback logic in datapath units.

---
 rtl/adder_pipe_carry.sv | 161 ++++++++++++++++
 tb/tb_adder_pipe_carry.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_carry.sv
// ----------------------------------------------------------------------------
// adder_pipe_carry
//
// Pipelined N-bit adder/subtractor with carry-in, carry-out and signed
// overflow. The carry chain is split into STAGES chunks of W = N/STAGES bits.
// Each pipeline stage resolves one chunk, so only a W-bit carry chain sits
// between registers. Both sides use a valid/ready handshake with full
// backpressure.
//
// Parameters:
//   N       operand/result width (must be a multiple of STAGES)
//   STAGES  pipeline depth and number of carry chunks (1..N)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; discards all in-flight beats
//   in_valid   operand beat valid
//   in_ready   pipeline can take a beat this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in for add, borrow-in for subtract
//   op_sub     0 = a+b+cin, 1 = a-b-cin
//   out_valid  result beat valid
//   out_ready  consumer takes the result this cycle
//   sum        result, modulo 2^N
//   cout       raw carry out of a + b_eff + c0 (for subtract, 1 = no borrow)
//   ovf        signed two's-complement overflow
// ----------------------------------------------------------------------------
module adder_pipe_carry #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    // Per-stage registers, index 0 is the first stage. Each stage carries
    // the full operands along so the next stage can pick its chunk; the
    // operand MSBs double as the sign bits needed for overflow at the end.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry_q;
    logic [N-1:0]      psum_q [STAGES];
    logic [N-1:0]      opa_q  [STAGES];
    logic [N-1:0]      opb_q  [STAGES];

    // Values each stage would load if it advanced this cycle.
    logic [STAGES-1:0] nxt_vld;
    logic [STAGES-1:0] nxt_carry;
    logic [N-1:0]      nxt_psum [STAGES];
    logic [N-1:0]      nxt_a    [STAGES];
    logic [N-1:0]      nxt_b    [STAGES];

    logic [STAGES-1:0] adv;
    logic [N-1:0]      b_eff;
    logic              c0;

    // Subtraction is folded into addition at the input: a - b - cin equals
    // a + ~b + ~cin, so the adder itself only ever adds.
    always_comb begin
        b_eff = op_sub ? ~b : b;
        c0    = op_sub ? ~cin : cin;
    end

    // Chunk adders. Stage j takes its operands from the input port (j == 0)
    // or from stage j-1, adds chunk j plus the incoming carry, and writes
    // that chunk into the partial sum. Lower chunks pass through unchanged.
    always_comb begin
        int         p;
        logic [N-1:0] src_p;
        logic         src_c;
        logic [W:0]   chunk;
        p     = 0;
        src_p = '0;
        src_c = 1'b0;
        chunk = '0;
        for (int j = 0; j < STAGES; j++) begin
            // p is a safe index for the previous stage; unused when j == 0
            p = (j == 0) ? 0 : j - 1;
            if (j == 0) begin
                nxt_vld[j] = in_valid;
                nxt_a[j]   = a;
                nxt_b[j]   = b_eff;
                src_c      = c0;
                src_p      = '0;
            end else begin
                nxt_vld[j] = vld_q[p];
                nxt_a[j]   = opa_q[p];
                nxt_b[j]   = opb_q[p];
                src_c      = carry_q[p];
                src_p      = psum_q[p];
            end
            chunk = {1'b0, nxt_a[j][j*W +: W]}
                  + {1'b0, nxt_b[j][j*W +: W]}
                  + {{W{1'b0}}, src_c};
            nxt_psum[j]          = src_p;
            nxt_psum[j][j*W +: W] = chunk[W-1:0];
            nxt_carry[j]         = chunk[W];
        end
    end

    // Advance chain, walked from the output back to the input. A stage
    // moves when it is empty or its successor moves, which lets bubbles
    // collapse even while the output is stalled. This makes in_ready
    // combinational from out_ready through the whole pipeline.
    always_comb begin
        logic down;
        down = out_ready;
        adv  = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            adv[j] = !vld_q[j] || down;
            down   = adv[j];
        end
    end

    assign in_ready = adv[0];

    // Stage registers. Reset clears data as well as valids so the result
    // port reads zero right after reset. Stalled stages simply hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            for (int j = 0; j < STAGES; j++) begin
                psum_q[j] <= '0;
                opa_q[j]  <= '0;
                opb_q[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                if (adv[j]) begin
                    vld_q[j]   <= nxt_vld[j];
                    carry_q[j] <= nxt_carry[j];
                    psum_q[j]  <= nxt_psum[j];
                    opa_q[j]   <= nxt_a[j];
                    opb_q[j]   <= nxt_b[j];
                end
            end
        end
    end

    // Outputs come straight from the last stage registers. Overflow: both
    // addends share a sign and the result sign differs from it.
    assign out_valid = vld_q[L];
    assign sum       = psum_q[L];
    assign cout      = carry_q[L];
    assign ovf       = (opa_q[L][N-1] == opb_q[L][N-1]) && (psum_q[L][N-1] != opa_q[L][N-1]);

endmodule

// File: tb/tb_adder_pipe_carry.sv
// ----------------------------------------------------------------------------
// tb_adder_pipe_carry
//
// Drives two instances of adder_pipe_carry (N=8/STAGES=2 and N=32/STAGES=4)
// sharing one clock and reset. Expected results come from an arithmetic
// model that computes a+b+cin or a-b-cin on wide integers and derives the
// carry and signed overflow from range checks.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_adder_pipe_carry;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        iv32, ir32, ov32, or32, cin32, sub32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    int tests = 0;
    int fails = 0;

    adder_pipe_carry #(.N(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .op_sub(sub8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    adder_pipe_carry #(.N(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32), .op_sub(sub32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    // Wide-integer reference: true sum/difference, carry = result did not
    // leave [0, 2^n), overflow = signed result left [-2^(n-1), 2^(n-1)).
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s, input int n);
        longint m, ua, ub, sa, sb, r, sr;
        res_t   res;
        m  = longint'(1) << n;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = s ? (ua - ub - longint'(c)) : (ua + ub + longint'(c));
        res.s = 32'(r & (m - 1));
        res.c = s ? (r >= 0) : (r >= m);
        sa = a[n-1] ? ua - m : ua;
        sb = b[n-1] ? ub - m : ub;
        sr = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
        res.o = (sr >= (m >>> 1)) || (sr < -(m >>> 1));
        return res;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        iv32 = 0; or32 = 1; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({ov8, sum8, cout8, ovf8, ir8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset8: got v=%b s=%h c=%b o=%b r=%b, expected 0 00 0 0 1", ov8, sum8, cout8, ovf8, ir8);
        end
        tests++;
        if ({ov32, sum32, cout32, ovf32, ir32} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset32: got v=%b s=%h c=%b o=%b r=%b, expected 0 0 0 0 1", ov32, sum32, cout32, ovf32, ir32);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single beats through the 8-bit/2-stage instance: the listed corner
    // cases first, then random beats against the model. Each beat checks
    // in_ready, a latency of exactly 2 cycles and the result.
    task automatic test_directed8();
        logic [7:0] ta [5] = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h80};
        logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h01};
        logic       tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] tes [5] = '{8'h00, 8'h80, 8'h01, 8'hFE, 8'h7F};
        logic       tec [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       teo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 25; i++) begin
            logic [7:0] es;
            logic       ec, eo;
            res_t       r;
            int         lat;
            @(negedge clk);
            or8 = 1'b1;
            if (i < 5) begin
                a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; sub8 = ts[i];
                es = tes[i]; ec = tec[i]; eo = teo[i];
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
                r  = model({24'b0, a8}, {24'b0, b8}, cin8, sub8, 8);
                es = r.s[7:0]; ec = r.c; eo = r.o;
            end
            iv8 = 1'b1;
            #1;
            tests++;
            if (ir8 !== 1'b1) begin
                fails++;
                $display("[TB] FAIL in_ready8 beat %0d: got %b expected 1", i, ir8);
            end
            @(negedge clk);
            iv8 = 1'b0;
            lat = 1;
            #1;
            while (ov8 !== 1'b1 && lat < 8) begin
                @(negedge clk);
                #1;
                lat++;
            end
            tests++;
            if (lat != 2) begin
                fails++;
                $display("[TB] FAIL latency8 beat %0d: got %0d cycles expected 2", i, lat);
            end
            tests++;
            if ({sum8, cout8, ovf8} !== {es, ec, eo}) begin
                fails++;
                $display("[TB] FAIL result8 beat %0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                         i, sum8, cout8, ovf8, es, ec, eo);
            end
        end
    endtask

    // Carry/borrow rippling through all four chunks of the 32-bit instance.
    task automatic test_ripple32();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0000};
        logic [31:0] tb [3] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000};
        logic        tc [3] = '{1'b1, 1'b0, 1'b1};
        logic        ts [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] tes [3] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_FFFF};
        logic        tec [3] = '{1'b1, 1'b0, 1'b0};
        logic        teo [3] = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            int lat;
            @(negedge clk);
            or32 = 1'b1;
            a32 = ta[i]; b32 = tb[i]; cin32 = tc[i]; sub32 = ts[i];
            iv32 = 1'b1;
            @(negedge clk);
            iv32 = 1'b0;
            lat = 1;
            #1;
            while (ov32 !== 1'b1 && lat < 12) begin
                @(negedge clk);
                #1;
                lat++;
            end
            tests++;
            if (lat != 4) begin
                fails++;
                $display("[TB] FAIL latency32 vec %0d: got %0d cycles expected 4", i, lat);
            end
            tests++;
            if ({sum32, cout32, ovf32} !== {tes[i], tec[i], teo[i]}) begin
                fails++;
                $display("[TB] FAIL ripple32 vec %0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                         i, sum32, cout32, ovf32, tes[i], tec[i], teo[i]);
            end
        end
    endtask

    // Streaming with backpressure. rand_mode=0: in_valid held high and
    // out_ready toggles every 3 cycles; rand_mode=1: both random. Checks
    // in_ready against occupancy, output stability during stalls, and
    // in-order results against a queue of model values.
    task automatic test_back_to_back32(input int nbeats, input bit rand_mode);
        res_t expq [$];
        res_t exp_r, held_v;
        int   sent, got, cyc, inflight;
        bit   pending, held, acc, con, exp_ir;
        sent = 0; got = 0; cyc = 0; inflight = 0; pending = 0; held = 0;
        held_v = '0;
        while (got < nbeats && cyc < 3000) begin
            @(negedge clk);
            or32 = rand_mode ? 1'($urandom_range(0, 1)) : (((cyc / 3) % 2) == 1);
            if (!pending && sent < nbeats) begin
                a32 = $urandom; b32 = $urandom;
                cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
                pending = 1;
            end
            iv32 = pending && (!rand_mode || ($urandom_range(0, 3) != 0));
            #1;
            exp_ir = (inflight < 4) || or32;
            tests++;
            if (ir32 !== exp_ir) begin
                fails++;
                $display("[TB] FAIL in_ready32 cycle %0d: got %b expected %b (occupancy %0d)", cyc, ir32, exp_ir, inflight);
            end
            if (held) begin
                tests++;
                if (ov32 !== 1'b1 || {sum32, cout32, ovf32} !== held_v) begin
                    fails++;
                    $display("[TB] FAIL stall_hold cycle %0d: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                             cyc, ov32, sum32, cout32, ovf32, held_v.s, held_v.c, held_v.o);
                end
            end
            con = (ov32 === 1'b1) && or32;
            if (con) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_out cycle %0d: got s=%h with no beat outstanding", cyc, sum32);
                end else begin
                    exp_r = expq.pop_front();
                    if ({sum32, cout32, ovf32} !== exp_r) begin
                        fails++;
                        $display("[TB] FAIL stream32 result %0d: got s=%h c=%b o=%b expected s=%h c=%b o=%b",
                                 got, sum32, cout32, ovf32, exp_r.s, exp_r.c, exp_r.o);
                    end
                end
                got++;
            end
            acc = iv32 && (ir32 === 1'b1);
            if (acc) begin
                expq.push_back(model(a32, b32, cin32, sub32, 32));
                sent++;
                pending = 0;
            end
            inflight = inflight + int'(acc) - int'(con);
            held   = (ov32 === 1'b1) && !or32;
            held_v = {sum32, cout32, ovf32};
            cyc++;
        end
        @(negedge clk);
        iv32 = 1'b0;
        or32 = 1'b1;
        tests++;
        if (got != nbeats) begin
            fails++;
            $display("[TB] FAIL stream32_count: got %0d results expected %0d", got, nbeats);
        end
    endtask

    // Three beats held in flight, then a one-edge reset: nothing from them
    // may ever come out and the pipeline must be ready again.
    task automatic test_reset_midstream();
        @(negedge clk);
        or32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a32 = $urandom; b32 = $urandom; cin32 = 1'b0; sub32 = 1'b0;
            iv32 = 1'b1;
            @(negedge clk);
        end
        iv32 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({ov32, sum32, ir32} !== {1'b0, 32'h0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL midreset: got v=%b s=%h r=%b expected v=0 s=0 r=1", ov32, sum32, ir32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        or32 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
                fails++;
                $display("[TB] FAIL stale_beat cycle %0d: got v=%b r=%b expected v=0 r=1", i, ov32, ir32);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_directed8();
        test_ripple32();
        test_back_to_back32(10, 1'b0);
        test_back_to_back32(40, 1'b1);
        test_reset_midstream();
        test_ripple32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
